// File: rtl/pdm_pkg.sv
// Constants shared by the PDM receive path and the PDM bit-clock generator,
// plus the helper that sizes a PCM sample for a given decimation ratio.
package pdm_pkg;

    localparam int PDM_DECIM_DEFAULT = 128;
    localparam int PDM_CLK_DIV       = 32;

    // A sample holds the ones-count of a window, i.e. 0..decim inclusive.
    function automatic int pdm_sample_w(input int decim);
        return $clog2(decim + 1);
    endfunction

    localparam int PDM_SAMPLE_W = $clog2(PDM_DECIM_DEFAULT + 1);

    typedef logic [PDM_SAMPLE_W-1:0] pdm_sample_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: counts ones over each DECIM-bit window and offers
// the count as a PCM sample through a single-entry valid/ready output register.
module pdm_mic_rx
    import pdm_pkg::*;
#(
    parameter int DECIM = PDM_DECIM_DEFAULT,
    parameter int OUT_W = pdm_sample_w(DECIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pdm_clk,
    input  logic             pdm_data,
    output logic [OUT_W-1:0] sample_tdata,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    localparam int               CNT_W    = $clog2(DECIM);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DECIM - 1);

    logic             d_s2;
    logic             pdm_clk_q;
    logic             seen_low_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [OUT_W-1:0] tdata_q, tdata_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             rise;
    logic             window_done;
    logic             handshake;
    logic [OUT_W-1:0] result;

    sync_2ff u_data_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pdm_data),
        .q_o (d_s2)
    );

    // pdm_clk_q resets low, so a pdm_clk that is already high at reset
    // release would look like a rise; seen_low_q holds edges off until
    // pdm_clk has actually been sampled low once.
    assign rise        = pdm_clk & ~pdm_clk_q & seen_low_q;
    assign window_done = rise && (bit_cnt_q == LAST_BIT);
    assign handshake   = valid_q & sample_ready;
    assign result      = OUT_W'(ones_q) + OUT_W'(d_s2);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ones_d    = ones_q;
        tdata_d   = tdata_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (handshake) begin
            valid_d = 1'b0;
        end

        if (rise) begin
            if (window_done) begin
                bit_cnt_d = '0;
                ones_d    = '0;
                if (!valid_q || handshake) begin
                    tdata_d = result;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                ones_d    = ones_q + CNT_W'(d_s2);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdm_clk_q  <= 1'b0;
            seen_low_q <= 1'b0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            tdata_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pdm_clk_q  <= pdm_clk;
            seen_low_q <= seen_low_q | ~pdm_clk;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            tdata_q    <= tdata_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sample_tdata = tdata_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Bench for pdm_mic_rx: drives a divided PDM clock and data patterns, keeps a
// window-sum reference model and a scoreboard of accepted samples.
module tb_pdm_mic_rx;
    import pdm_pkg::*;

    localparam int DECIM      = PDM_DECIM_DEFAULT;
    localparam int OUT_W      = $clog2(DECIM + 1);
    localparam int HALF       = PDM_CLK_DIV / 2;
    localparam int PER_NS     = PDM_CLK_DIV * 10;
    localparam int WIN_BUDGET = DECIM * PDM_CLK_DIV + 200;

    localparam int M_ONE  = 0;
    localparam int M_ZERO = 1;
    localparam int M_ALT  = 2;
    localparam int M_RAND = 3;
    localparam int M_MAN  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             pdm_clk;
    logic             pdm_data;
    logic [OUT_W-1:0] sample_tdata;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;

    int               mode = M_ONE;
    int               m_bits = 0;
    int               m_ones = 0;
    int               win_cnt = 0;
    int               win_q[$];
    logic [OUT_W-1:0] exp_q[$];
    logic [OUT_W-1:0] acc_q[$];
    int               ovr_cnt = 0;
    int               exp_ovr = 0;
    int               cmp_cnt = 0;
    int               err_cnt = 0;

    pdm_mic_rx #(
        .DECIM (DECIM),
        .OUT_W (OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .sample_tdata (sample_tdata),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    // clock block
    initial begin
        forever #5 clk = ~clk;
    end

    // PDM bit clock (changes on negedge) with data driven on its falling edge;
    // the reference model records the data bit at every rise outside reset.
    initial begin
        pdm_clk  = 1'b0;
        pdm_data = 1'b0;
        forever begin
            repeat (HALF) @(negedge clk);
            pdm_clk = ~pdm_clk;
            if (pdm_clk) begin
                if (rst === 1'b0) begin
                    m_bits++;
                    m_ones += int'(pdm_data);
                    if (m_bits == DECIM) begin
                        win_q.push_back(m_ones);
                        win_cnt++;
                        m_bits = 0;
                        m_ones = 0;
                    end
                end
            end else begin
                case (mode)
                    M_ONE:   pdm_data = 1'b1;
                    M_ZERO:  pdm_data = 1'b0;
                    M_ALT:   pdm_data = ~pdm_data;
                    M_RAND:  pdm_data = 1'($urandom_range(0, 1));
                    default: ;
                endcase
            end
        end
    end

    // accepted samples and overrun pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sample_valid === 1'b1 && sample_ready === 1'b1) acc_q.push_back(sample_tdata);
            if (overrun === 1'b1) ovr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits until the model has completed window number 'target'; returns at
    // the first sample point after the completing rise.
    task automatic wait_win(input int target, input string tag, output int early);
        int n;
        early = 0;
        n = 0;
        while (win_cnt < target && n < WIN_BUDGET) begin
            step();
            n++;
            if (win_cnt < target && sample_valid === 1'b1) early++;
        end
        if (win_cnt < target) timeout_fail(tag);
    endtask

    task automatic wait_bits(input int target, input string tag);
        int n;
        n = 0;
        while (m_bits != target && n < WIN_BUDGET) begin
            step();
            n++;
        end
        if (m_bits != target) timeout_fail(tag);
    endtask

    function automatic int pop_model();
        if (win_q.size() == 0) return -1;
        return win_q.pop_front();
    endfunction

    task automatic check_win(input string tag, input int exp_v);
        check({tag, "_valid"}, 32'(sample_valid), 1);
        check({tag, "_tdata"}, 32'(sample_tdata), exp_v);
        check({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    // One window with ready held high: sample appears right after completion
    // and is accepted on the next edge.
    task automatic run_win(input string tag, input int exp_const, input bit use_model);
        int early;
        int v;
        wait_win(win_cnt + 1, {tag, "_timeout"}, early);
        v = pop_model();
        if (use_model) check_win(tag, v);
        else           check_win(tag, exp_const);
        exp_q.push_back(use_model ? OUT_W'(v) : OUT_W'(exp_const));
        check({tag, "_early"}, early, 0);
        step();
        check({tag, "_pulse"}, 32'(sample_valid), 0);
    endtask

    initial begin
        int n;
        int target;
        int early;
        int v;

        rst          = 1'b1;
        sample_ready = 1'b0;
        mode         = M_ONE;
        repeat (4) step();
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_tdata", 32'(sample_tdata), 0);
        check("rst_overrun", 32'(overrun), 0);

        // release reset while pdm_clk is high: that level must not count
        n = 0;
        while (pdm_clk !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        step();
        step();
        rst          = 1'b0;
        sample_ready = 1'b1;

        run_win("ones0", DECIM, 1'b0);
        run_win("ones1", DECIM, 1'b0);
        mode = M_ZERO;
        run_win("zeros", 0, 1'b0);
        mode = M_ALT;
        run_win("alt", DECIM / 2, 1'b0);
        mode = M_RAND;
        run_win("rand0", 0, 1'b1);
        run_win("rand1", 0, 1'b1);

        // backpressure across two completions
        mode         = M_ONE;
        sample_ready = 1'b0;
        wait_win(win_cnt + 1, "bp1_timeout", early);
        v = pop_model();
        check_win("bp_first", DECIM);
        exp_q.push_back(OUT_W'(DECIM));
        wait_win(win_cnt + 1, "bp2_timeout", early);
        v = pop_model();
        check("bp_overrun", 32'(overrun), 1);
        check("bp_valid_held", 32'(sample_valid), 1);
        check("bp_tdata_held", 32'(sample_tdata), DECIM);
        exp_ovr++;
        step();
        check("bp_overrun_pulse", 32'(overrun), 0);
        check("bp_tdata_still", 32'(sample_tdata), DECIM);
        sample_ready = 1'b1;
        step();
        check("bp_one_handshake", 32'(sample_valid), 0);

        // ready raised only on the completion cycle while a sample is held
        sample_ready = 1'b0;
        wait_win(win_cnt + 1, "rc1_timeout", early);
        v = pop_model();
        check_win("rc_first", DECIM);
        exp_q.push_back(OUT_W'(DECIM));
        wait_bits(DECIM - 1, "rc_bits_timeout");
        target = win_cnt + 1;
        #(PER_NS - 10);
        sample_ready = 1'b1;
        wait_win(target, "rc2_timeout", early);
        sample_ready = 1'b0;
        v = pop_model();
        check_win("rc_second", DECIM);
        exp_q.push_back(OUT_W'(DECIM));
        step();
        check("rc_valid_kept", 32'(sample_valid), 1);
        sample_ready = 1'b1;
        step();
        check("rc_drained", 32'(sample_valid), 0);

        // reset at bit 50 of an all-ones window
        wait_bits(50, "mid_bits_timeout");
        rst    = 1'b1;
        m_bits = 0;
        m_ones = 0;
        repeat (3) step();
        check("mid_rst_valid", 32'(sample_valid), 0);
        rst = 1'b0;
        run_win("post_rst", DECIM, 1'b0);

        // data switched 1->0 one clk before the pdm_clk rise: old bit captured
        wait_bits(DECIM - 1, "sync_old_bits_timeout");
        mode   = M_MAN;
        target = win_cnt + 1;
        #(PER_NS - 16);
        pdm_data = 1'b0;
        wait_win(target, "sync_old_timeout", early);
        mode = M_ONE;
        v = pop_model();
        check_win("sync_old", DECIM);
        exp_q.push_back(OUT_W'(DECIM));
        step();

        // data switched two clks before the rise: new bit captured
        wait_bits(DECIM - 1, "sync_new_bits_timeout");
        mode   = M_MAN;
        target = win_cnt + 1;
        #(PER_NS - 26);
        pdm_data = 1'b0;
        wait_win(target, "sync_new_timeout", early);
        mode = M_ONE;
        v = pop_model();
        check_win("sync_new", DECIM - 1);
        exp_q.push_back(OUT_W'(DECIM - 1));

        repeat (5) step();

        // final report
        check("acc_count", acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
            check($sformatf("acc_data%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        end
        check("overrun_count", ovr_cnt, exp_ovr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
